dpram_arbiter: RTL and testbench

Shares a single port of a `dpram` instance between up to four internal requesters, e.g. CPU, input-log DMA and a debug reader. It arbitrates per cycle, drives the RAM port from registers and returns a per-requester `ack` pulse. For reads, it also returns data aligned with the RAM's one-cycle registered output. It sits between the requesters and `dpram` port A or B, and owns that port exclusively.

---
 rtl/dpram_arb_pkg.sv | 31 +++
 rtl/dpram_arb_pick.sv | 39 +++
 rtl/dpram_arbiter.sv | 116 +++++++++++
 tb/tb_dpram_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared types and winner selection for dpram_arbiter.
// Build option: DPRAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package dpram_arb_pkg;

  localparam int unsigned MAX_REQUESTERS = 4;
  localparam int unsigned IDX_W          = 2;

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic valid;
    idx_t idx;
  } rd_tag_t;

  // Search starts at last+1; wrapping over all four slots matches wrapping at
  // REQUESTERS-1 because absent requesters are zero in the mask.
  function automatic logic [MAX_REQUESTERS-1:0] rr_pick(
    input logic [MAX_REQUESTERS-1:0] mask,
    input idx_t                      last
  );
    logic [MAX_REQUESTERS-1:0] grant;
    idx_t                      cand;
    grant = '0;
    for (int unsigned k = 1; k <= MAX_REQUESTERS; k++) begin
      cand = last + idx_t'(k);
      if (grant == '0 && mask[cand]) grant[cand] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/dpram_arb_pick.sv
// Combinational winner selection for dpram_arbiter.
// DPRAM_ARB_FIXED_PRIO_EN: lowest index wins and no last-grant input exists.
module dpram_arb_pick
  import dpram_arb_pkg::*;
#(
  parameter int unsigned REQUESTERS = 3
) (
  input  logic [REQUESTERS-1:0] i_mask,
`ifndef DPRAM_ARB_FIXED_PRIO_EN
  input  idx_t                  i_last,
`endif
  output logic [REQUESTERS-1:0] o_grant,
  output idx_t                  o_idx,
  output logic                  o_valid
);

  logic [MAX_REQUESTERS-1:0] w_mask;
  logic [MAX_REQUESTERS-1:0] w_pick;

  assign w_mask = MAX_REQUESTERS'(i_mask);

`ifdef DPRAM_ARB_FIXED_PRIO_EN
  // Starting the rotating search after the top slot gives plain lowest-index priority.
  assign w_pick = rr_pick(w_mask, idx_t'(MAX_REQUESTERS - 1));
`else
  assign w_pick = rr_pick(w_mask, i_last);
`endif

  always_comb begin
    o_idx = '0;
    for (int unsigned i = 0; i < MAX_REQUESTERS; i++) begin
      if (w_pick[i]) o_idx = idx_t'(i);
    end
  end

  assign o_grant = w_pick[REQUESTERS-1:0];
  assign o_valid = |w_pick;

endmodule

// File: rtl/dpram_arbiter.sv
// Arbitrates up to four requesters onto one registered dpram port; write acks
// come from the issue stage, read acks one cycle later from a read tag.
// Build option: DPRAM_ARB_FIXED_PRIO_EN (fixed priority, no last_grant register).
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int unsigned REQUESTERS = 3,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [REQUESTERS-1:0]        req,
  input  logic [REQUESTERS-1:0]        we,
  input  logic [REQUESTERS*ADDR_W-1:0] addr,
  input  logic [REQUESTERS*DATA_W-1:0] wdata,
  output logic [REQUESTERS-1:0]        ack,
  output logic [DATA_W-1:0]            rdata,
  output logic                         ram_wren,
  output logic [ADDR_W-1:0]            ram_address,
  output logic [DATA_W-1:0]            ram_data,
  input  logic [DATA_W-1:0]            ram_q
);

  logic [REQUESTERS-1:0] r_pending;
  logic                  r_iss_v;
  idx_t                  r_iss_idx;
  rd_tag_t               r_tag;
  logic                  r_ram_wren;
  logic [ADDR_W-1:0]     r_ram_address;
  logic [DATA_W-1:0]     r_ram_data;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
  idx_t                  r_last;
`endif

  logic [REQUESTERS-1:0] w_mask;
  logic [REQUESTERS-1:0] w_grant;
  idx_t                  w_idx;
  logic                  w_valid;
  logic                  w_we;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic [REQUESTERS-1:0] w_ack;

  assign w_mask = req & ~r_pending;

  dpram_arb_pick #(
    .REQUESTERS(REQUESTERS)
  ) u_pick (
    .i_mask (w_mask),
`ifndef DPRAM_ARB_FIXED_PRIO_EN
    .i_last (r_last),
`endif
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_valid(w_valid)
  );

  always_comb begin
    w_we    = 1'b0;
    w_addr  = '0;
    w_wdata = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      if (w_grant[i]) begin
        w_we    = we[i];
        w_addr  = addr[i*ADDR_W +: ADDR_W];
        w_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes complete in the issue cycle, reads one cycle later via the tag.
  always_comb begin
    w_ack = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      w_ack[i] = (r_ram_wren && r_iss_idx == idx_t'(i)) ||
                 (r_tag.valid && r_tag.idx == idx_t'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending     <= '0;
      r_iss_v       <= 1'b0;
      r_iss_idx     <= '0;
      r_tag         <= '0;
      r_ram_wren    <= 1'b0;
      r_ram_address <= '0;
      r_ram_data    <= '0;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
      r_last        <= idx_t'(REQUESTERS - 1);
`endif
    end else begin
      r_tag.valid <= r_iss_v & ~r_ram_wren;
      r_tag.idx   <= r_iss_idx;
      r_iss_v     <= w_valid;
      r_ram_wren  <= w_valid & w_we;
      r_pending   <= (r_pending & ~w_ack) | w_grant;
      if (w_valid) begin
        r_iss_idx     <= w_idx;
        r_ram_address <= w_addr;
        r_ram_data    <= w_wdata;
`ifndef DPRAM_ARB_FIXED_PRIO_EN
        r_last        <= w_idx;
`endif
      end
    end
  end

  assign ack         = w_ack;
  assign rdata       = ram_q;
  assign ram_wren    = r_ram_wren;
  assign ram_address = r_ram_address;
  assign ram_data    = r_ram_data;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Scoreboard bench for dpram_arbiter with a behavioural single-port RAM model.
module tb_dpram_arbiter;

  localparam int R  = 3;
  localparam int AW = 10;
  localparam int DW = 8;

  logic            clk;
  logic            reset_n;
  logic [R-1:0]    req;
  logic [R-1:0]    we;
  logic [R*AW-1:0] addr;
  logic [R*DW-1:0] wdata;
  logic [R-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            ram_wren;
  logic [AW-1:0]   ram_address;
  logic [DW-1:0]   ram_data;
  logic [DW-1:0]   ram_q;

  dpram_arbiter #(
    .REQUESTERS(R),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .ack        (ack),
    .rdata      (rdata),
    .ram_wren   (ram_wren),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_q      (ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    ram_q = '0;
  end
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  typedef struct {
    int          idx;
    bit          rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int idx, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.idx = idx; e.rd = rd; e.a = a; e.d = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (reset_n === 1'b1 && ack !== '0) begin
      if (sbq.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        check("ack_id", 32'(ack), 32'(1 << mon_e.idx));
        if (mon_e.rd) begin
          check("rdata", 32'(rdata), 32'(mon_e.d));
        end else begin
          check("wr_wren", 32'(ram_wren), 32'd1);
          check("wr_addr", 32'(ram_address), 32'(mon_e.a));
          check("wr_data", 32'(ram_data), 32'(mon_e.d));
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge ending the ack cycle.
  task automatic access(input int i, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int exp_lat);
    int lat;
    bit got;
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
    req[i] = 1'b1;
    sbq.push_back(mk(i, !w, a, d));
    lat = 0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      lat++;
      if (ack[i]) got = 1;
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    else      check("ack_latency", 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && sbq.size() != 0; k++) @(negedge clk);
    check(name, 32'(sbq.size()), 32'd0);
  endtask

  int order [6];

  initial begin
    reset_n = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    #2;
    reset_n = 1'b0;
    req = 3'b111; we = 3'b111;
    addr  = {10'h102, 10'h101, 10'h100};
    wdata = {8'h12, 8'h11, 8'h10};
    repeat (2) begin
      @(negedge clk);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_wren", 32'(ram_wren), 32'd0);
      check("rst_addr", 32'(ram_address), 32'd0);
      check("rst_data", 32'(ram_data), 32'd0);
    end

`ifdef DPRAM_ARB_FIXED_PRIO_EN
    order = '{0, 1, 0, 1, 0, 1};
`else
    order = '{0, 1, 2, 0, 1, 2};
`endif
    foreach (order[k])
      sbq.push_back(mk(order[k], 1'b0, AW'(10'h100 + order[k]), DW'(8'h10 + order[k])));
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    req = '0;
    drain("drain_contention");
    @(posedge clk); #1;

    access(1, 1'b1, 10'h123, 8'hA5, 2);
    access(1, 1'b0, 10'h123, 8'hA5, 3);
    access(0, 1'b0, 10'h101, 8'h11, 3);

    fork
      access(0, 1'b1, 10'h010, 8'h3C, 2);
      begin
        @(posedge clk); #1;
        access(2, 1'b0, 10'h010, 8'h3C, 3);
      end
    join
    drain("drain_mixed");
    @(posedge clk); #1;

    we[1] = 1'b0; addr[1*AW +: AW] = 10'h123; req[1] = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    req[1] = 1'b0;
    @(negedge clk);
    check("midrd_ack", 32'(ack), 32'd0);
    check("midrd_wren", 32'(ram_wren), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("midrd_noack", 32'(ack), 32'd0);
    end
    @(posedge clk); #1;
    access(1, 1'b0, 10'h123, 8'hA5, 3);

    access(2, 1'b1, 10'h2F0, 8'h77, 2);
    repeat (5) begin
      @(negedge clk);
      check("idle_wren", 32'(ram_wren), 32'd0);
      check("idle_addr", 32'(ram_address), 32'h2F0);
      check("idle_data", 32'(ram_data), 32'h77);
    end
    @(posedge clk); #1;
    access(0, 1'b0, 10'h2F0, 8'h77, 3);

    drain("drain_final");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
